// File: rtl/draw_pkg.sv
// Shared drawing definitions: screen geometry, VGA field widths and blitter states.
package draw_pkg;
  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned COLOUR_W = 9;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} blit_state_t;
endpackage

// File: rtl/blit_scan_counter.sv
// Raster-order col/row/address counter for a W x H sprite; the address
// increments alongside col/row, so no multiplier is needed.
module blit_scan_counter
  import draw_pkg::*;
#(
  parameter int unsigned W      = 80,
  parameter int unsigned H      = 40,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clear,
  output logic [X_W-1:0]    col,
  output logic [Y_W-1:0]    row,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  localparam logic [X_W-1:0] COL_MAX = X_W'(W - 1);
  localparam logic [Y_W-1:0] ROW_MAX = Y_W'(H - 1);

  logic col_end;

  assign col_end = (col == COL_MAX);
  assign last    = col_end && (row == ROW_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (clear) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (en) begin
      if (col_end) begin
        col <= '0;
        // Wrap everything after the final pixel so the next blit starts at 0.
        if (last) begin
          row  <= '0;
          addr <= '0;
        end else begin
          row  <= row + 1'b1;
          addr <= addr + 1'b1;
        end
      end else begin
        col  <= col + 1'b1;
        addr <= addr + 1'b1;
      end
    end
  end
endmodule

// File: rtl/draw_sprite_blit.sv
// Sprite blitter: scans a W x H colour ROM and streams clipped, optionally
// colour-keyed pixels at a runtime origin, one per clock.
module draw_sprite_blit
  import draw_pkg::*;
#(
  parameter int unsigned W          = 80,
  parameter int unsigned H          = 40,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned COLOUR_W   = 9,
  parameter int unsigned ROM_LAT    = 1,
  parameter int unsigned TRANSP_EN  = 0,
  parameter logic [COLOUR_W-1:0] TRANSP_KEY = 9'h1FF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [X_W-1:0]      origin_x,
  input  logic [Y_W-1:0]      origin_y,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_q,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);
  blit_state_t    state;
  logic [X_W-1:0] org_x;
  logic [Y_W-1:0] org_y;
  logic [1:0]     drain_cnt;

  logic           cnt_en;
  logic           cnt_clear;
  logic           cnt_last;
  logic [X_W-1:0] cnt_col;
  logic [Y_W-1:0] cnt_row;

  logic           vld_pipe [ROM_LAT];
  logic [X_W-1:0] col_pipe [ROM_LAT];
  logic [Y_W-1:0] row_pipe [ROM_LAT];

  logic           vld_d;
  logic [X_W:0]   sum_x;
  logic [Y_W:0]   sum_y;
  logic           clip;
  logic           transp;

  assign cnt_en    = (state == SCAN);
  assign cnt_clear = (state == IDLE) && start;

  blit_scan_counter #(
    .W      (W),
    .H      (H),
    .ADDR_W (ADDR_W)
  ) u_scan (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en),
    .clear (cnt_clear),
    .col   (cnt_col),
    .row   (cnt_row),
    .addr  (rom_addr),
    .last  (cnt_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      org_x     <= '0;
      org_y     <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // busy stays up through the done cycle and only drops here.
          busy <= start;
          if (start) begin
            org_x <= origin_x;
            org_y <= origin_y;
            state <= SCAN;
          end
        end
        SCAN: begin
          busy <= 1'b1;
          if (cnt_last) begin
            drain_cnt <= '0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          busy <= 1'b1;
          if (drain_cnt == 2'(ROM_LAT - 1)) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // col/row/valid travel alongside the ROM read so they line up with rom_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ROM_LAT; i++) begin
        vld_pipe[i] <= 1'b0;
        col_pipe[i] <= '0;
        row_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0] <= (state == SCAN);
      col_pipe[0] <= cnt_col;
      row_pipe[0] <= cnt_row;
      for (int unsigned i = 1; i < ROM_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        col_pipe[i] <= col_pipe[i-1];
        row_pipe[i] <= row_pipe[i-1];
      end
    end
  end

  assign vld_d  = vld_pipe[ROM_LAT-1];
  assign sum_x  = {1'b0, org_x} + {1'b0, col_pipe[ROM_LAT-1]};
  assign sum_y  = {1'b0, org_y} + {1'b0, row_pipe[ROM_LAT-1]};
  assign clip   = (sum_x >= (X_W+1)'(SCREEN_W)) || (sum_y >= (Y_W+1)'(SCREEN_H));
  assign transp = (TRANSP_EN != 0) && (rom_q == TRANSP_KEY);

  assign x      = sum_x[X_W-1:0];
  assign y      = sum_y[Y_W-1:0];
  assign colour = vld_d ? rom_q : '0;
  assign plot   = vld_d && !clip && !transp;
endmodule

// File: doc/draw_sprite_blit.md
# draw_sprite_blit

Parametrised rectangular sprite blitter. On a `start` pulse it scans a W×H image stored in an external synchronous colour ROM and streams one pixel per clock to the VGA adapter as (x, y, colour, plot), offset by a runtime origin. It supports transparent-colour masking and screen-edge clipping. It is the shared drawing engine behind every screen and stage overlay in the game's draw FSM, replacing the fixed-size, fixed-origin per-image drawers.

## Interface

**Parameters**
- `W`, default 80: sprite width in pixels, ≥1.
- `H`, default 40: sprite height in pixels, ≥1.
- `ADDR_W`, default 12: ROM address width; must satisfy 2^ADDR_W ≥ W*H.
- `COLOUR_W`, default 9: colour width (3 bits per channel).
- `ROM_LAT`, default 1: ROM read latency in clocks, 1 or 2.
- `TRANSP_EN`, default 0: when 1, pixels equal to `TRANSP_KEY` are not plotted.
- `TRANSP_KEY`, default 9'h1FF: transparent colour value.

**Ports**
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: begin a blit; sampled only in IDLE.
- `origin_x`, in, 8: screen x of the sprite's top-left pixel; latched on accepted `start`.
- `origin_y`, in, 7: screen y of the sprite's top-left pixel; latched on accepted `start`.
- `rom_addr`, out, ADDR_W: ROM read address.
- `rom_q`, in, COLOUR_W: ROM data, valid ROM_LAT clocks after `rom_addr`.
- `x`, out, 8: VGA x.
- `y`, out, 7: VGA y.
- `colour`, out, COLOUR_W: VGA colour.
- `plot`, out, 1: VGA write enable.
- `busy`, out, 1: high from the accepted `start` until `done`, inclusive of the `done` cycle.
- `done`, out, 1: one-cycle completion pulse.

## Operation

- **States:** IDLE → SCAN → DRAIN → IDLE.
- **IDLE:**
  - `start`=1 latches the origin, clears col/row, and moves to SCAN.
  - `busy` goes high the next cycle.
- **SCAN:**
  - Each cycle issues `rom_addr` = row*W + col. The address is kept by an incrementing counter; no multiplier.
  - col runs 0..W-1. At col = W-1, col wraps to 0 and row increments.
  - After issuing address W*H-1, the FSM moves to DRAIN.
- **DRAIN:** waits for ROM_LAT cycles so in-flight pixels emerge, then pulses `done` and returns to IDLE.
- **Pipeline:**
  - col, row and a valid bit are delayed ROM_LAT stages to align with `rom_q`.
  - x = origin_x + col_d, y = origin_y + row_d, computed at full screen width.
- **Plot conditions:** `plot` = valid_d AND NOT clip AND NOT (TRANSP_EN AND `rom_q` == TRANSP_KEY).
- **Clipping:** clip = (origin_x + col_d ≥ 160) OR (origin_y + row_d ≥ 120). Evaluate the sum one bit wider than the screen field, so there is no wrap-around onto the left or top edge.
- **Outputs when not plotting:** `x`, `y` and `colour` remain driven, but only `plot` qualifies them.
- **Start handling:** `start` while `busy` is ignored. `start` held high through `done` starts a new blit on the cycle after `done`.
- **Reset:**
  - Asynchronous, takes effect mid-blit. State = IDLE; counters, origin latches and pipeline valid = 0.
  - `busy`=0, `done`=0, `plot`=0, `rom_addr`=0, `x`=0, `y`=0, `colour`=0.
  - No pixel is plotted after reset asserts.

## Timing

- `start` is accepted at edge k. `rom_addr` for pixel i (raster order, i = row*W + col) is driven in cycle k+1+i.
- Pixel i appears on `x`/`y`/`colour`/`plot` in cycle k+1+i+ROM_LAT.
- The last pixel appears in cycle k+W*H+ROM_LAT.
- `done`=1 in cycle k+W*H+ROM_LAT+1; `busy` falls the cycle after.
- Total blit length is W*H+ROM_LAT+1 cycles. Throughput is 1 pixel per clock with no bubbles at row wrap.
- W=1 or H=1 must work: the row wrap and the final address coincide.

## Structure

- **Shared package `draw_pkg`:**
  - SCREEN_W=160, SCREEN_H=120.
  - X_W=8, Y_W=7, COLOUR_W=9.
  - Blit state enum {IDLE, SCAN, DRAIN}.
- **Sub-module `blit_scan_counter`:**
  - Parametrised W×H col/row/address counter.
  - Ports: `en`, `clear`, col, row, addr, `last`.
- **Top level:** the FSM, the ROM_LAT delay line, and the clip/transparency logic.

## Test plan

1. **Basic blit.** W=4, H=2, ROM_LAT=1, ROM[i]=i, origin (10,20), `start` at edge k.
   - Plots (10..13,20) then (10..13,21) with colours 0..7, in cycles k+2..k+9.
   - `done` in cycle k+10 only.
2. **Transparency.** TRANSP_EN=1, TRANSP_KEY=3, ROM[3]=3, otherwise the same as test 1.
   - `plot`=0 only in cycle k+5; seven plots total; `done` timing unchanged.
3. **Clipping.** Origin (158,119), W=4, H=2.
   - Plots only (158,119) and (159,119).
   - No write ever lands at x<4 or y=0.
   - `done` still at k+10.
4. **Start during busy, then back-to-back.** `start` pulsed at k+4 is ignored. `start` held high continuously produces a second blit whose first `rom_addr`=0 is in the cycle after `done`.
5. **Reset mid-blit.** Assert `reset` during cycle k+5.
   - Outputs go to zero immediately and `busy`=0.
   - After release, no `plot` until a new `start`; the new blit begins at address 0.
6. **Latency and degenerate size.** ROM_LAT=2 with W=1, H=3: three plots at k+3..k+5, `done` at k+6.
